// File: rtl/alu_shift_iter.sv
// ---------------------------------------------------------------------------
// alu_shift_iter
// Multi-cycle iterative shifter for the MIPS ALU datapath. It produces the
// same results as the combinational SLL/SRL/SRA shifter, but shifts STEP bit
// positions per clock behind a start/busy/done handshake.
//
// Parameters
//   WIDTH  data width (32 for MIPS)
//   STEP   bit positions shifted per active cycle (1, 2, 4 or 8)
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset; abandons any in-flight op
//   start   request strobe, sampled only while not busy (IDLE or DONE)
//   ALUFun  100000 SLL, 100001 SRL, 100011 SRA; anything else is illegal
//   A       A[4:0] is the shift amount; the upper bits are ignored
//   B       operand to shift
//   S       result register, written only on a completion edge
//   busy    high while a shift is in flight
//   done    one-cycle completion pulse
//   err     set together with done when the accepted ALUFun was illegal
// ---------------------------------------------------------------------------
module alu_shift_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       ALUFun,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA} op_t;

  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;
  localparam logic [4:0] STEP_N  = 5'(STEP);

  state_t           state, next_state;
  op_t              op_q, op_dec;
  logic [4:0]       count_q;
  logic [WIDTH-1:0] work_q;
  logic             sign_q;

  logic             accept;
  logic             legal;
  logic [4:0]       shamt;
  logic [4:0]       n;
  logic             last_step;
  logic [WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] sra_ext;

  // Only the shift amount of A is architecturally meaningful.
  logic unused_a_hi;
  assign unused_a_hi = ^A[WIDTH-1:5];

  assign shamt     = A[4:0];
  assign accept    = start && (state != SHIFT);
  assign last_step = (count_q <= STEP_N);
  assign n         = last_step ? count_q : STEP_N;

  // Opcode decode.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    legal  = 1'b1;
    op_dec = OP_SLL;
    case (ALUFun)
      FUN_SLL: op_dec = OP_SLL;
      FUN_SRL: op_dec = OP_SRL;
      FUN_SRA: op_dec = OP_SRA;
      default: legal  = 1'b0;
    endcase
  end

  // One iteration of the small shifter. SRA fills from the sign bit captured
  // at acceptance rather than the current work MSB.
  always_comb begin
    sra_ext = {{WIDTH{sign_q}}, work_q} >> n;
    shifted = work_q;
    case (op_q)
      OP_SLL:  shifted = work_q << n;
      OP_SRL:  shifted = work_q >> n;
      OP_SRA:  shifted = sra_ext[WIDTH-1:0];
      default: shifted = work_q;
    endcase
  end

  // FSM state register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the edge, independent of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next-state logic. DONE accepts a new start just like IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (!accept)                      next_state = IDLE;
        else if (!legal || shamt == 5'd0) next_state = DONE;
        else                              next_state = SHIFT;
      end
      SHIFT:   next_state = last_step ? DONE : SHIFT;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Datapath: operand capture, iteration and result write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      S       <= '0;
      err     <= 1'b0;
      count_q <= '0;
      work_q  <= '0;
      sign_q  <= 1'b0;
      op_q    <= OP_SLL;
    end else if (accept) begin
      op_q    <= op_dec;
      count_q <= shamt;
      work_q  <= B;
      sign_q  <= B[WIDTH-1];
      err     <= !legal;
      // Zero-length and illegal ops complete on the capture edge itself.
      if (!legal)               S <= '0;
      else if (shamt == 5'd0)   S <= B;
    end else if (state == SHIFT) begin
      work_q  <= shifted;
      count_q <= count_q - n;
      if (last_step) S <= shifted;
    end
  end

endmodule
